// File: rtl/spi_register_controller.sv
// Byte-level command sequencer between the SPI peripheral byte interface and a register bank.
// Each chip-select frame is one command byte (rw + start address) followed by a data burst.
module spi_register_controller #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ss_active_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_byte_i,
    output logic [7:0]            tx_byte_o,
    output logic                  tx_load_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic [7:0]            reg_wdata_o,
    output logic                  reg_we_o,
    input  logic [7:0]            reg_rdata_i,
    output logic                  busy_o,
    output logic                  cmd_err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRload,
        StRdata,
        StDiscard
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [7:0]            NumRegsB = 8'(NUM_REGS);

    state_e                state_q, state_d;
    logic                  ss_prev_q;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  tx_load_q, tx_load_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]            reg_wdata_q, reg_wdata_d;
    logic                  reg_we_q, reg_we_d;
    logic                  cmd_err_q, cmd_err_d;

    logic                  ss_rise;
    logic                  cmd_bad;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign ss_rise  = ss_active_i & ~ss_prev_q;
    assign cmd_bad  = {1'b0, rx_byte_i[6:0]} >= NumRegsB;
    assign cmd_addr = ADDR_WIDTH'(rx_byte_i[6:0]);
    assign addr_inc = (reg_addr_q == LastAddr) ? '0 : reg_addr_q + 1'b1;

    // State and datapath registers. Sampling ss_active during reset means a
    // frame already in progress at reset release never produces a rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ss_prev_q   <= ss_active_i;
            tx_byte_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_prev_q   <= ss_active_i;
            tx_byte_q   <= tx_byte_d;
            tx_load_q   <= tx_load_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ss_rise) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (!ss_active_i) begin
                    state_d = StIdle;
                end else if (rx_valid_i) begin
                    if (cmd_bad) begin
                        state_d = StDiscard;
                    end else if (rx_byte_i[7]) begin
                        state_d = StRload;
                    end else begin
                        state_d = StWdata;
                    end
                end
            end
            StWdata: begin
                if (!ss_active_i) begin
                    state_d = StIdle;
                end
            end
            StRload: begin
                state_d = ss_active_i ? StRdata : StIdle;
            end
            StRdata: begin
                if (!ss_active_i) begin
                    state_d = StIdle;
                end else if (rx_valid_i) begin
                    state_d = StRload;
                end
            end
            StDiscard: begin
                if (!ss_active_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_byte_d   = tx_byte_q;
        tx_load_d   = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        cmd_err_d   = cmd_err_q;

        // Address advances in the cycle after the write strobe so the strobe sees the old address.
        if (reg_we_q) begin
            reg_addr_d = addr_inc;
        end

        unique case (state_q)
            StIdle: begin
                if (ss_rise) begin
                    tx_byte_d = STATUS_BYTE;
                    tx_load_d = 1'b1;
                    cmd_err_d = 1'b0;
                end
            end
            StCmd: begin
                if (rx_valid_i) begin
                    if (cmd_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        reg_addr_d = cmd_addr;
                    end
                end
            end
            StWdata: begin
                // A byte landing together with the frame end is still written.
                if (rx_valid_i) begin
                    reg_we_d    = 1'b1;
                    reg_wdata_d = rx_byte_i;
                end
            end
            StRload: begin
                if (ss_active_i) begin
                    tx_byte_d = reg_rdata_i;
                    tx_load_d = 1'b1;
                end
            end
            StRdata: begin
                if (rx_valid_i && ss_active_i) begin
                    reg_addr_d = addr_inc;
                end
            end
            StDiscard: begin
            end
            default: begin
            end
        endcase
    end

    assign tx_byte_o   = tx_byte_q;
    assign tx_load_o   = tx_load_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign busy_o      = (state_q != StIdle);
    assign cmd_err_o   = cmd_err_q;

    strobe_exclusive_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(reg_we_o && tx_load_o));
    tx_load_single_a: assert property (@(posedge clk_i) disable iff (rst_i)
        tx_load_o |=> !tx_load_o);

endmodule

// File: doc/spi_register_controller.md
Name: spi_register_controller

Overview:
- Byte-level command sequencer between the SPI peripheral's byte interface and a register bank (LED, neuron-parameter and status registers).
- Each chip-select frame from the RPi is decoded as one command byte followed by a burst of data bytes.
- For each frame it issues register writes, or preloads read data for transmission, with auto-incrementing address.
- Runs in the fabric clock domain; SPI byte strobes arrive already synchronised into that domain.

Parameters:
- NUM_REGS, 16: number of addressable registers; valid addresses 0..NUM_REGS-1; legal range 1..128.
- ADDR_WIDTH, 7: width of reg_addr; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- STATUS_BYTE, 8'hA5: byte shifted out to the master during the command byte.

Ports:
- clk  input  1  fabric clock; must be at least 4x sck.
- rst  input  1  synchronous, active-high reset.
- ss_active  input  1  synchronised chip-select; 1 = frame in progress.
- rx_valid  input  1  one-cycle pulse: rx_byte holds a completed received byte.
- rx_byte  input  8  received byte.
- tx_byte  output  8  next byte for the peripheral to shift out.
- tx_load  output  1  one-cycle pulse: peripheral latches tx_byte.
- reg_addr  output  ADDR_WIDTH  register address.
- reg_wdata  output  8  write data.
- reg_we  output  1  one-cycle write strobe.
- reg_rdata  input  8  read data; combinational from reg_addr.
- busy  output  1  1 while state != IDLE.
- cmd_err  output  1  sticky error; cleared at the next frame start.

Behaviour:
- Reset: state=IDLE. tx_byte=0, tx_load=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, cmd_err=0. Reset mid-frame aborts the frame with no write issued; the rest of that frame is ignored until ss_active returns to 0.
- Command byte format: bit7 = rw (1 = read, 0 = write); bits6:0 = start address.
- IDLE:
  - On ss_active rising (registered edge detect): tx_byte<=STATUS_BYTE, tx_load pulse, cmd_err<=0, go to CMD.
  - ss_active already high when leaving reset: stay in IDLE.
- CMD: on rx_valid, latch the command.
  - Address >= NUM_REGS: cmd_err<=1, go to DISCARD.
  - Write: reg_addr<=addr, go to WDATA.
  - Read: reg_addr<=addr, go to RLOAD.
- RLOAD (one cycle): tx_byte<=reg_rdata, tx_load pulse, go to RDATA.
  - Latency from the command rx_valid to tx_load is exactly 2 cycles.
- RDATA: each rx_valid (master dummy byte) advances reg_addr by one and goes to RLOAD, preloading the next register.
- WDATA: each rx_valid produces, in the next cycle:
  - reg_we=1 with reg_wdata=rx_byte and reg_addr = current address.
  - Then reg_addr increments. Write latency is 1 cycle after rx_valid.
- Address increment: at NUM_REGS-1 the address wraps to 0. Applies to both read and write bursts.
- DISCARD: ignore rx_valid; tx_load is never pulsed.
- Frame end, from any non-IDLE state: ss_active=0 returns to IDLE next cycle.
  - If rx_valid coincides with ss_active falling, the byte is processed first: a pending write still issues and reg_we fires in that cycle.
  - A read preload is dropped.
- Strobes: reg_we and tx_load are at most one cycle wide and never asserted together. reg_we never asserts outside WDATA.
- A command byte alone (frame ends after one byte) is legal and produces no write.

Test Plan:
- Write burst: frame bytes 8'h03, 8'h11, 8'h22 -> reg_we pulses at addr 3 data 8'h11, then addr 4 data 8'h22; no other reg_we; busy drops 1 cycle after ss_active falls.
- Read burst: reg model 2->8'h5A, 3->8'hC3; frame bytes 8'h82, 8'h00, 8'h00 -> tx_load sequence STATUS_BYTE, then 8'h5A 2 cycles after the first rx_valid, then 8'hC3; reg_we never asserts.
- Wrap: NUM_REGS=16, frame bytes 8'h0F, 8'hAA, 8'hBB -> writes addr 15=8'hAA, addr 0=8'hBB.
- Bad address: command 8'h20 with NUM_REGS=16, then 3 data bytes -> cmd_err=1, no reg_we, no tx_load after STATUS_BYTE; next valid frame start clears cmd_err.
- Frame end coinciding with data: rx_valid with byte 8'h77 in the same cycle ss_active falls during a write to addr 5 -> reg_we at addr 5 data 8'h77, state IDLE the following cycle.
- Reset mid-frame: rst asserted after the write command byte 8'h01, then data 8'h44 while ss_active is held -> no reg_we, all outputs 0; the next frame behaves normally.
